// File: rtl/driver_update_scheduler_if.sv
// Bus bundle between the motor sequencer and the H-bridge update scheduler.
// The master side issues shadow writes, commit/run requests and run settings.
// The slave side (the scheduler) returns the driver pins and status.
interface driver_update_scheduler_if #(
  parameter int NUM_OF_DRIVERS = 8,
  parameter int ADDR_W         = 3,
  parameter int CNT_W          = 8,
  parameter int REP_W          = 8
) ();

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [ADDR_W-1:0]           cmd_addr;
  logic [CNT_W-1:0]            cmd_duty;
  logic                        cmd_dir;
  logic                        cmd_en;
  logic                        latch_data;
  logic                        control_trigger;
  logic [CNT_W-1:0]            period;
  logic [REP_W-1:0]            repeat_count;
  logic [2*NUM_OF_DRIVERS-1:0] driver_io;
  logic                        busy;
  logic                        update_cycle_complete;

  modport master (
    output cmd_valid, cmd_addr, cmd_duty, cmd_dir, cmd_en,
    output latch_data, control_trigger, period, repeat_count,
    input  cmd_ready, driver_io, busy, update_cycle_complete
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_duty, cmd_dir, cmd_en,
    input  latch_data, control_trigger, period, repeat_count,
    output cmd_ready, driver_io, busy, update_cycle_complete
  );

endinterface

// File: rtl/driver_update_scheduler.sv
// Update scheduler for the H-bridge driver pins of the motor sequencer.
// Per-driver settings land in shadow registers; a latch edge copies them into
// the active set one driver per cycle; a trigger edge plays period*repeat_count
// PWM cycles on every enabled driver, then pulses update_cycle_complete.
module driver_update_scheduler #(
  parameter int NUM_OF_DRIVERS = 8,
  parameter int ADDR_W         = 3,
  parameter int CNT_W          = 8,
  parameter int REP_W          = 8
) (
  input logic                      clock,
  input logic                      reset,
  driver_update_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   NUM_ADDR = (ADDR_W+1)'(NUM_OF_DRIVERS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OF_DRIVERS - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [REP_W-1:0]  REP_ZERO = {REP_W{1'b0}};
  localparam logic [2*NUM_OF_DRIVERS-1:0] IO_ZERO = {(2*NUM_OF_DRIVERS){1'b0}};

  // Pin pair for one driver; the two legs are never driven high together.
  function automatic logic [1:0] pair_code(input logic en, input logic dir, input logic on);
    logic [1:0] code;
    if (en && on) begin
      code = dir ? 2'b01 : 2'b10;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction

  state_t                      state_r;
  logic [ADDR_W-1:0]           idx_r;
  logic [CNT_W-1:0]            per_r;
  logic [CNT_W-1:0]            pwm_cnt_r;
  logic [REP_W-1:0]            rep_r;
  logic [REP_W-1:0]            rep_cnt_r;
  logic                        latch_prev_r;
  logic                        trig_prev_r;
  logic [2*NUM_OF_DRIVERS-1:0] driver_io_r;
  logic                        busy_r;
  logic                        complete_r;

  logic [CNT_W-1:0]            sh_duty_r  [NUM_OF_DRIVERS];
  logic [NUM_OF_DRIVERS-1:0]   sh_dir_r;
  logic [NUM_OF_DRIVERS-1:0]   sh_en_r;
  logic [CNT_W-1:0]            act_duty_r [NUM_OF_DRIVERS];
  logic [NUM_OF_DRIVERS-1:0]   act_dir_r;
  logic [NUM_OF_DRIVERS-1:0]   act_en_r;

  logic                        latch_edge_s;
  logic                        trig_edge_s;
  logic                        ready_s;
  logic                        cmd_fire_s;
  logic                        run_zero_s;
  logic                        frame_end_s;
  logic                        run_last_s;
  logic                        start_live_s;
  logic [CNT_W-1:0]            cnt_next_s;
  logic [2*NUM_OF_DRIVERS-1:0] pattern_s;

  // Rising-edge detection against the previous cycle's level.
  always_comb begin
    latch_edge_s = bus.latch_data & ~latch_prev_r;
    trig_edge_s  = bus.control_trigger & ~trig_prev_r;
  end

  // Shadow writes are accepted only while idle or running, never under reset.
  always_comb begin
    ready_s = 1'b0;
    if (reset) begin
      ready_s = 1'b0;
    end else if ((state_r == ST_IDLE) || (state_r == ST_RUN)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    cmd_fire_s = bus.cmd_valid & ready_s;
  end

  // Frame bookkeeping and the PWM count the pins will reflect next cycle.
  always_comb begin
    run_zero_s   = (per_r == CNT_ZERO) || (rep_r == REP_ZERO);
    frame_end_s  = (pwm_cnt_r == (per_r - CNT_W'(1)));
    run_last_s   = frame_end_s && (rep_cnt_r == (rep_r - REP_W'(1)));
    start_live_s = (bus.period != CNT_ZERO) && (bus.repeat_count != REP_ZERO);
    cnt_next_s   = CNT_ZERO;
    if ((state_r == ST_RUN) && !frame_end_s) begin
      cnt_next_s = pwm_cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = CNT_ZERO;
    end
  end

  // Pin pattern for every driver at the upcoming PWM count.
  always_comb begin
    pattern_s = IO_ZERO;
    for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
      pattern_s[2*i +: 2] = pair_code(act_en_r[i], act_dir_r[i], cnt_next_s < act_duty_r[i]);
    end
  end

  // Edge history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      latch_prev_r <= 1'b0;
      trig_prev_r  <= 1'b0;
    end else begin
      latch_prev_r <= bus.latch_data;
      trig_prev_r  <= bus.control_trigger;
    end
  end

  // Shadow register file; out-of-range addresses are accepted and dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
        sh_duty_r[i] <= CNT_ZERO;
      end
      sh_dir_r <= {NUM_OF_DRIVERS{1'b0}};
      sh_en_r  <= {NUM_OF_DRIVERS{1'b0}};
    end else if (cmd_fire_s && ({1'b0, bus.cmd_addr} < NUM_ADDR)) begin
      sh_duty_r[bus.cmd_addr] <= bus.cmd_duty;
      sh_dir_r[bus.cmd_addr]  <= bus.cmd_dir;
      sh_en_r[bus.cmd_addr]   <= bus.cmd_en;
    end
  end

  // Active register file; one driver copied from shadow per COMMIT cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
        act_duty_r[i] <= CNT_ZERO;
      end
      act_dir_r <= {NUM_OF_DRIVERS{1'b0}};
      act_en_r  <= {NUM_OF_DRIVERS{1'b0}};
    end else if (state_r == ST_COMMIT) begin
      act_duty_r[idx_r] <= sh_duty_r[idx_r];
      act_dir_r[idx_r]  <= sh_dir_r[idx_r];
      act_en_r[idx_r]   <= sh_en_r[idx_r];
    end
  end

  // Sequencer: state, run counters and the registered pin/status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= {ADDR_W{1'b0}};
      per_r       <= CNT_ZERO;
      rep_r       <= REP_ZERO;
      pwm_cnt_r   <= CNT_ZERO;
      rep_cnt_r   <= REP_ZERO;
      driver_io_r <= IO_ZERO;
      busy_r      <= 1'b0;
      complete_r  <= 1'b0;
    end else begin
      complete_r  <= 1'b0;
      driver_io_r <= IO_ZERO;
      case (state_r)
        ST_IDLE: begin
          if (latch_edge_s) begin
            // A simultaneous trigger edge is deliberately dropped here.
            state_r <= ST_COMMIT;
            idx_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b1;
          end else if (trig_edge_s) begin
            state_r   <= ST_RUN;
            per_r     <= bus.period;
            rep_r     <= bus.repeat_count;
            pwm_cnt_r <= CNT_ZERO;
            rep_cnt_r <= REP_ZERO;
            busy_r    <= 1'b1;
            // First frame cycle shows on the pins as soon as RUN is entered.
            driver_io_r <= start_live_s ? pattern_s : IO_ZERO;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_COMMIT: begin
          if (idx_r == LAST_IDX) begin
            state_r <= ST_IDLE;
            idx_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_COMMIT;
            idx_r   <= idx_r + ADDR_W'(1);
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          busy_r <= 1'b1;
          if (run_zero_s || run_last_s) begin
            state_r    <= ST_DONE;
            complete_r <= 1'b1;
          end else begin
            state_r     <= ST_RUN;
            pwm_cnt_r   <= cnt_next_s;
            driver_io_r <= pattern_s;
            if (frame_end_s) begin
              rep_cnt_r <= rep_cnt_r + REP_W'(1);
            end else begin
              rep_cnt_r <= rep_cnt_r;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready             = ready_s;
  assign bus.driver_io             = driver_io_r;
  assign bus.busy                  = busy_r;
  assign bus.update_cycle_complete = complete_r;

endmodule

// File: tb/tb_driver_update_scheduler.sv
// Bench for driver_update_scheduler: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// timeline model built from the behavioural rules.
module tb_driver_update_scheduler;

  localparam int NUM = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  driver_update_scheduler_if #(.NUM_OF_DRIVERS(8), .ADDR_W(3), .CNT_W(8), .REP_W(8)) bus ();

  driver_update_scheduler #(.NUM_OF_DRIVERS(8), .ADDR_W(3), .CNT_W(8), .REP_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model state: settings, the current job as a timeline, edge history.
  int  m_duty [NUM];
  bit  m_dir  [NUM];
  bit  m_en   [NUM];
  int  a_duty [NUM];
  bit  a_dir  [NUM];
  bit  a_en   [NUM];
  int  job_kind;   // 0 none, 1 commit, 2 run
  int  job_w;
  int  job_p;
  int  job_r;
  bit  job_zero;
  bit  lat_prev, trg_prev, rst_prev;
  int  win;
  bit  chk_en;
  int  checks, failures;

  // Levels driven in the next window.
  logic       lat_lv, trg_lv, rst_lv;
  logic [7:0] per_lv, rep_lv;

  // Samples and tallies taken in each window.
  logic [15:0] s_io;
  logic        s_busy, s_cmpl, s_ready;
  int t_p2, t_p5, t_other, t_any, t_busy, t_nready, t_cmpl;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s win=%0d actual=%0h expected=%0h", name, win, act, exp);
    end
  endtask

  // Window c: 0 idle, 1 commit, 2 run, 3 done.
  function automatic int model_state(input int c);
    int n;
    if (job_kind == 1 && c >= job_w + 1 && c <= job_w + NUM) return 1;
    if (job_kind == 2) begin
      n = job_zero ? 1 : job_p * job_r;
      if (c >= job_w + 1 && c <= job_w + n) return 2;
      if (c == job_w + n + 1) return 3;
    end
    return 0;
  endfunction

  function automatic logic [15:0] exp_io(input int c);
    logic [15:0] r;
    int ph;
    r = 16'h0000;
    if (model_state(c) == 2 && !job_zero) begin
      ph = (c - job_w - 1) % job_p;
      for (int i = 0; i < NUM; i++) begin
        if (a_en[i] && ph < a_duty[i]) r[2*i +: 2] = a_dir[i] ? 2'b01 : 2'b10;
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM; i++) begin
      m_duty[i] = 0; m_dir[i] = 1'b0; m_en[i] = 1'b0;
      a_duty[i] = 0; a_dir[i] = 1'b0; a_en[i] = 1'b0;
    end
    job_kind = 0;
    lat_prev = 1'b0;
    trg_prev = 1'b0;
  endtask

  task automatic model_apply(input bit v, input int a, input int d, input bit dr, input bit e);
    int st;
    if (rst_prev) model_clear();
    st = model_state(win);
    if (!rst_lv) begin
      if (v && (st == 0 || st == 2) && a < NUM) begin
        m_duty[a] = d; m_dir[a] = dr; m_en[a] = e;
      end
      if (st == 0 && lat_lv && !lat_prev) begin
        job_kind = 1; job_w = win;
        for (int i = 0; i < NUM; i++) begin
          a_duty[i] = m_duty[i]; a_dir[i] = m_dir[i]; a_en[i] = m_en[i];
        end
      end else if (st == 0 && trg_lv && !trg_prev) begin
        job_kind = 2; job_w = win;
        job_p = int'(per_lv); job_r = int'(rep_lv);
        job_zero = (job_p == 0) || (job_r == 0);
      end
    end
    lat_prev = lat_lv;
    trg_prev = trg_lv;
    rst_prev = rst_lv;
  endtask

  task automatic clear_tally();
    t_p2 = 0; t_p5 = 0; t_other = 0; t_any = 0; t_busy = 0; t_nready = 0; t_cmpl = 0;
  endtask

  // One clock window: drive inputs, advance the model, sample outputs.
  task automatic tick(input bit v, input int a, input int d, input bit dr, input bit e);
    @(posedge clock);
    #1;
    win = win + 1;
    reset               = rst_lv;
    bus.cmd_valid       = v;
    bus.cmd_addr        = 3'(a);
    bus.cmd_duty        = 8'(d);
    bus.cmd_dir         = dr;
    bus.cmd_en          = e;
    bus.latch_data      = lat_lv;
    bus.control_trigger = trg_lv;
    bus.period          = per_lv;
    bus.repeat_count    = rep_lv;
    model_apply(v, a, d, dr, e);
    #1;
    s_io    = bus.driver_io;
    s_busy  = bus.busy;
    s_cmpl  = bus.update_cycle_complete;
    s_ready = bus.cmd_ready;
    if (s_io[5:4] == 2'b10) t_p2++;
    if (s_io[11:10] == 2'b01) t_p5++;
    if ((s_io & 16'hF3CF) != 16'h0000) t_other++;
    if (s_io != 16'h0000) t_any++;
    if (s_busy) t_busy++;
    if (!s_ready) t_nready++;
    if (s_cmpl) t_cmpl++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Per-cycle comparison of every output against the model timeline.
  always @(negedge clock) begin : cmp
    int st;
    if (chk_en) begin
      st = model_state(win);
      chk("io", int'(bus.driver_io), int'(exp_io(win)));
      chk("busy", int'(bus.busy), (st != 0) ? 1 : 0);
      chk("complete", int'(bus.update_cycle_complete), (st == 3) ? 1 : 0);
      chk("ready", int'(bus.cmd_ready), (!reset && (st == 0 || st == 2)) ? 1 : 0);
    end
  end

  initial begin
    int rst_cnt;
    checks = 0; failures = 0; win = 0; chk_en = 1'b0;
    lat_lv = 1'b0; trg_lv = 1'b0; rst_lv = 1'b1; per_lv = 8'd0; rep_lv = 8'd0;
    rst_prev = 1'b1;
    model_clear();
    bus.cmd_valid = 1'b0; bus.cmd_addr = 3'd0; bus.cmd_duty = 8'd0;
    bus.cmd_dir = 1'b0; bus.cmd_en = 1'b0; bus.latch_data = 1'b0;
    bus.control_trigger = 1'b0; bus.period = 8'd0; bus.repeat_count = 8'd0;

    // 1: reset for 3 cycles, then release
    tick(1'b0, 0, 0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle(2);
    chk("t1_io", int'(s_io), 0);
    chk("t1_busy", int'(s_busy), 0);
    chk("t1_cmpl", int'(s_cmpl), 0);
    chk("t1_ready_rst", int'(s_ready), 0);
    rst_lv = 1'b0;
    idle(1);
    chk("t1_ready", int'(s_ready), 1);

    // 2: program d2 and d5, commit, then run period=4 repeat=2
    tick(1'b1, 2, 3, 1'b0, 1'b1);
    tick(1'b1, 5, 10, 1'b1, 1'b1);
    clear_tally();
    lat_lv = 1'b1; idle(1); lat_lv = 1'b0; idle(10);
    chk("t2_commit_busy", t_busy, 8);
    chk("t2_commit_nready", t_nready, 8);
    clear_tally();
    per_lv = 8'd4; rep_lv = 8'd2;
    trg_lv = 1'b1; idle(1); trg_lv = 1'b0; idle(11);
    chk("t2_p2_on", t_p2, 6);
    chk("t2_p5_on", t_p5, 8);
    chk("t2_other", t_other, 0);
    chk("t2_cmpl", t_cmpl, 1);

    // 3: shadow write without latch leaves the active duty untouched
    tick(1'b1, 2, 1, 1'b0, 1'b1);
    clear_tally();
    trg_lv = 1'b1; idle(1); trg_lv = 1'b0; idle(11);
    chk("t3_p2_on", t_p2, 6);

    // 4: latch and trigger edges together -> commit only
    clear_tally();
    lat_lv = 1'b1; trg_lv = 1'b1; idle(1); lat_lv = 1'b0; trg_lv = 1'b0; idle(11);
    chk("t4_busy", t_busy, 8);
    chk("t4_cmpl", t_cmpl, 0);
    chk("t4_io", t_any, 0);

    // 5: zero period, then zero repeat
    for (int z = 0; z < 2; z++) begin
      per_lv = (z == 0) ? 8'd0 : 8'd4;
      rep_lv = (z == 0) ? 8'd3 : 8'd0;
      clear_tally();
      trg_lv = 1'b1; idle(1); trg_lv = 1'b0;
      idle(1);
      chk("t5_early", int'(s_cmpl), 0);
      idle(1);
      chk("t5_pulse", int'(s_cmpl), 1);
      idle(2);
      chk("t5_io", t_any, 0);
    end

    // 6: reset in the middle of a run
    per_lv = 8'd5; rep_lv = 8'd3;
    trg_lv = 1'b1; idle(1); trg_lv = 1'b0; idle(4);
    rst_lv = 1'b1; idle(1);
    idle(1);
    chk("t6_io_reset", int'(s_io), 0);
    chk("t6_busy_reset", int'(s_busy), 0);
    rst_lv = 1'b0; idle(1);
    per_lv = 8'd4; rep_lv = 8'd2;
    clear_tally();
    trg_lv = 1'b1; idle(1); trg_lv = 1'b0; idle(11);
    chk("t6_io_after", t_any, 0);
    chk("t6_cmpl", t_cmpl, 1);

    // Randomized traffic
    rst_cnt = 0;
    for (int k = 0; k < 700; k++) begin
      if (rst_cnt > 0) begin
        rst_lv = 1'b1; rst_cnt--;
      end else begin
        rst_lv = 1'b0;
        if ($urandom_range(0, 249) == 0) rst_cnt = 2;
      end
      if ($urandom_range(0, 11) == 0) lat_lv = ~lat_lv;
      if ($urandom_range(0, 4) == 0) trg_lv = ~trg_lv;
      per_lv = 8'($urandom_range(0, 6));
      rep_lv = 8'($urandom_range(0, 3));
      tick(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    rst_lv = 1'b0; lat_lv = 1'b0; trg_lv = 1'b0;
    idle(25);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
